// File: rtl/f32_argmax_seq.sv
// Streams a vector of binary32 values through one shared greater-than compare
// and reports the maximum element, its index, and whether every element was NaN.
module f32_argmax_seq #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nan
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic f32_is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Subnormals flush to +0 so that signed zeros and tiny values compare equal.
    function automatic logic f32_gt(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb;
        logic [30:0] ma, mb;
        logic        res;
        sa  = (a[30:23] == 8'd0) ? 1'b0  : a[31];
        sb  = (b[30:23] == 8'd0) ? 1'b0  : b[31];
        ma  = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
        mb  = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
        res = 1'b0;
        if (f32_is_nan(a) || f32_is_nan(b)) begin
            res = 1'b0;
        end else begin
            case ({sa, sb})
                2'b00:   res = (ma > mb);
                2'b01:   res = 1'b1;
                2'b10:   res = 1'b0;
                2'b11:   res = (ma < mb);
                default: res = 1'b0;
            endcase
        end
        return res;
    endfunction

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [31:0]      r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_best_vld;

    logic             w_hs;
    logic             w_take;
    logic             w_last;
    logic [31:0]      w_nb;
    logic [IDX_W-1:0] w_nb_idx;
    logic             w_nb_vld;
    logic [LEN_W-1:0] w_len_sat;

    // Running-best update for the element currently offered.
    always_comb begin
        w_hs      = in_valid & in_ready;
        w_take    = ~f32_is_nan(in_data) & (~r_best_vld | f32_gt(in_data, r_best));
        w_last    = (r_count == (r_len - {{(LEN_W-1){1'b0}}, 1'b1}));
        w_len_sat = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        if (w_hs && w_take) begin
            w_nb     = in_data;
            w_nb_idx = r_count[IDX_W-1:0];
            w_nb_vld = 1'b1;
        end else begin
            w_nb     = r_best;
            w_nb_idx = r_best_idx;
            w_nb_vld = r_best_vld;
        end
    end

    // Job sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= {LEN_W{1'b0}};
            r_count    <= {LEN_W{1'b0}};
            r_best     <= 32'd0;
            r_best_idx <= {IDX_W{1'b0}};
            r_best_vld <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_max    <= 32'd0;
            out_idx    <= {IDX_W{1'b0}};
            out_nan    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= w_len_sat;
                        r_count    <= {LEN_W{1'b0}};
                        r_best_vld <= 1'b0;
                        busy       <= 1'b1;
                        if (w_len_sat == {LEN_W{1'b0}}) begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            out_nan   <= 1'b1;
                            out_max   <= QNAN;
                            out_idx   <= {IDX_W{1'b0}};
                        end else begin
                            r_state  <= S_RUN;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_best     <= w_nb;
                        r_best_idx <= w_nb_idx;
                        r_best_vld <= w_nb_vld;
                        r_count    <= r_count + {{(LEN_W-1){1'b0}}, 1'b1};
                        if (w_last) begin
                            r_state   <= S_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_nan   <= ~w_nb_vld;
                            out_max   <= w_nb_vld ? w_nb : QNAN;
                            out_idx   <= w_nb_vld ? w_nb_idx : {IDX_W{1'b0}};
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
